display_driver: RTL and testbench

DISPLAY_DRIVER -- requirements
Module: display_driver

---
 rtl/display_driver.sv | 221 ++++++++++++++++++++++
 tb/tb_display_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/display_driver.sv
// display_driver: 16-bit binary to 5-digit decimal converter feeding an 8-digit
//   multiplexed 7-segment display (digits 0..4 value, 5 separator, 6 prog, 7 src).
// Latency: display registers update 17 edges after the edge that samples data_valid in IDLE.
// Backpressure: none; words arriving while busy are held in a one-deep, last-wins pending slot.
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   data_in[15:0]       word to display, qualified by data_valid (with prog_in, src_in)
//   prog_in[2:0]        program number shown on digit 6
//   src_in              source tag shown on digit 7: 0 = "F", 1 = "t"
//   an[7:0]             active-low digit enables (one low bit)
//   dec_ddp[7:0]        active-low segments {a,b,c,d,e,f,g,dp}
//   busy                high while converting or loading
module display_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic [2:0]  prog_in,
  input  logic        src_in,
  output logic [7:0]  an,
  output logic [7:0]  dec_ddp,
  output logic        busy
);

  localparam int            CW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t      state, state_nxt;
  logic        start_live, start_pend, do_step, do_load;

  logic [3:0]  step;
  logic [15:0] bin;
  logic [19:0] bcd, bcd_adj;
  logic [2:0]  cap_prog;
  logic        cap_src;

  logic        pend_vld;
  logic [15:0] pend_dat;
  logic [2:0]  pend_prog;
  logic        pend_src;

  logic [19:0] disp_bcd, disp_bcd_nxt;
  logic [2:0]  disp_prog, disp_prog_nxt;
  logic        disp_src, disp_src_nxt;

  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx, idx_nxt;
  logic          scan_wrap;

  // Double-dabble correction: any BCD nibble >= 5 gets +3 so the next shift carries correctly.
  function automatic logic [19:0] dd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h03;
      4'd1:    s = 8'h9F;
      4'd2:    s = 8'h25;
      4'd3:    s = 8'h0D;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h49;
      4'd6:    s = 8'h41;
      4'd7:    s = 8'h1F;
      4'd8:    s = 8'h01;
      4'd9:    s = 8'h09;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  function automatic logic [7:0] digit_code(input logic [2:0]  i,
                                            input logic [19:0] b,
                                            input logic [2:0]  p,
                                            input logic        s);
    logic [19:0] hi;
    logic [7:0]  c;
    // hi holds this digit and everything above it; all-zero means a leading zero.
    hi = b >> {i, 2'b00};
    case (i)
      3'd0:    c = seg_code(b[3:0]);
      3'd5:    c = 8'hFE;
      3'd6:    c = seg_code({1'b0, p});
      3'd7:    c = s ? 8'hE1 : 8'h71;
      default: c = (hi == 20'd0) ? 8'hFF : seg_code(hi[3:0]);
    endcase
    return c;
  endfunction

  assign busy    = (state != IDLE);
  assign bcd_adj = dd_adjust(bcd);

  // Next-state and control decode.
  always_comb begin
    state_nxt  = state;
    start_live = 1'b0;
    start_pend = 1'b0;
    do_step    = 1'b0;
    do_load    = 1'b0;
    case (state)
      IDLE: begin
        if (data_valid) begin
          start_live = 1'b1;
          state_nxt  = CONVERT;
        end
      end
      CONVERT: begin
        do_step = 1'b1;
        if (step == 4'd15) state_nxt = LOAD;
      end
      LOAD: begin
        do_load = 1'b1;
        // A live word wins; any pending word waits for the next LOAD.
        if (data_valid) begin
          start_live = 1'b1;
          state_nxt  = CONVERT;
        end else if (pend_vld) begin
          start_pend = 1'b1;
          state_nxt  = CONVERT;
        end else begin
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Conversion datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      step     <= 4'd0;
      bin      <= 16'd0;
      bcd      <= 20'd0;
      cap_prog <= 3'd0;
      cap_src  <= 1'b0;
    end else if (start_live) begin
      step     <= 4'd0;
      bin      <= data_in;
      bcd      <= 20'd0;
      cap_prog <= prog_in;
      cap_src  <= src_in;
    end else if (start_pend) begin
      step     <= 4'd0;
      bin      <= pend_dat;
      bcd      <= 20'd0;
      cap_prog <= pend_prog;
      cap_src  <= pend_src;
    end else if (do_step) begin
      step       <= step + 4'd1;
      {bcd, bin} <= {bcd_adj[18:0], bin, 1'b0};
    end
  end

  // Pending slot: only words arriving mid-conversion land here; in LOAD a word is used directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld  <= 1'b0;
      pend_dat  <= 16'd0;
      pend_prog <= 3'd0;
      pend_src  <= 1'b0;
    end else if (start_pend) begin
      pend_vld  <= 1'b0;
    end else if (state == CONVERT && data_valid) begin
      pend_vld  <= 1'b1;
      pend_dat  <= data_in;
      pend_prog <= prog_in;
      pend_src  <= src_in;
    end
  end

  // Display registers change only in LOAD, so a partial conversion never shows.
  assign disp_bcd_nxt  = do_load ? bcd      : disp_bcd;
  assign disp_prog_nxt = do_load ? cap_prog : disp_prog;
  assign disp_src_nxt  = do_load ? cap_src  : disp_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd  <= 20'd0;
      disp_prog <= 3'd0;
      disp_src  <= 1'b0;
    end else begin
      disp_bcd  <= disp_bcd_nxt;
      disp_prog <= disp_prog_nxt;
      disp_src  <= disp_src_nxt;
    end
  end

  // Scan: an and dec_ddp are registered from next-cycle values so both switch together.
  assign scan_wrap = (scan_cnt == CNT_MAX);
  assign idx_nxt   = scan_wrap ? idx + 3'd1 : idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
      an       <= 8'hFE;
      dec_ddp  <= 8'h03;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      idx      <= idx_nxt;
      an       <= ~(8'b1 << idx_nxt);
      dec_ddp  <= digit_code(idx_nxt, disp_bcd_nxt, disp_prog_nxt, disp_src_nxt);
    end
  end

endmodule

// File: tb/tb_display_driver.sv
module tb_display_driver;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic        data_valid = 1'b0;
  logic [2:0]  prog_in = 3'd0;
  logic        src_in = 1'b0;
  logic [7:0]  an;
  logic [7:0]  dec_ddp;
  logic        busy;

  always #5 clk = ~clk;

  display_driver #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .prog_in    (prog_in),
    .src_in     (src_in),
    .an         (an),
    .dec_ddp    (dec_ddp),
    .busy       (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0]     dat;
    logic [2:0]      prog;
    logic            src;
    logic [7:0][7:0] dig;   // dig[i] = expected dec_ddp for digit i
  } vec_t;

  vec_t vecs [7];

  function automatic vec_t mk(input logic [15:0] d, input logic [2:0] p, input logic s,
                              input logic [7:0][7:0] g);
    vec_t v;
    v.dat  = d;
    v.prog = p;
    v.src  = s;
    v.dig  = g;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, "/an"},   {24'd0, an},      32'hFE);
    chk({nm, "/dec"},  {24'd0, dec_ddp}, 32'h03);
    chk({nm, "/busy"}, {31'd0, busy},    32'd0);
    rst = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [2:0] p, input logic s);
    @(negedge clk);
    data_in    = d;
    prog_in    = p;
    src_in     = s;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  // Counts negedges with busy high until it drops (bounded).
  task automatic busy_len(input string nm, input int exp_n, input int start_n);
    int n;
    n = start_n;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    chk({nm, "/busy_len"}, n, exp_n);
  endtask

  // Watches one full scan; checks an is one-hot-low, walks upward, and each digit's code.
  task automatic check_digits(input logic [7:0][7:0] exp, input string nm);
    logic [7:0] seen;
    int idx, prev;
    seen = 8'h00;
    prev = -1;
    for (int c = 0; c < 48 && seen != 8'hFF; c++) begin
      @(negedge clk);
      chk({nm, "/onehot"}, $countones(~an), 1);
      idx = 0;
      for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
      if (prev >= 0 && idx != prev) chk({nm, "/walk"}, idx, (prev + 1) % 8);
      prev = idx;
      if (!seen[idx]) begin
        seen[idx] = 1'b1;
        chk($sformatf("%s/dig%0d", nm, idx), {24'd0, dec_ddp}, {24'd0, exp[idx]});
      end
    end
    chk({nm, "/all_seen"}, {24'd0, seen}, 32'hFF);
  endtask

  localparam logic [7:0][7:0] ZERO_DISP = {8'h71, 8'h03, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};

  initial begin
    logic [7:0] prev_an;
    bit         found;

    // digit order in each literal: {d7, d6, d5, d4, d3, d2, d1, d0}
    vecs[0] = mk(16'd65535, 3'd5, 1'b1, {8'hE1, 8'h49, 8'hFE, 8'h41, 8'h49, 8'h49, 8'h0D, 8'h49});
    vecs[1] = mk(16'd7,     3'd0, 1'b0, {8'h71, 8'h03, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F});
    vecs[2] = mk(16'd12345, 3'd2, 1'b0, {8'h71, 8'h25, 8'hFE, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49});
    vecs[3] = mk(16'd0,     3'd7, 1'b1, {8'hE1, 8'h1F, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03});
    vecs[4] = mk(16'd10000, 3'd3, 1'b0, {8'h71, 8'h0D, 8'hFE, 8'h9F, 8'h03, 8'h03, 8'h03, 8'h03});
    vecs[5] = mk(16'd908,   3'd6, 1'b1, {8'hE1, 8'h41, 8'hFE, 8'hFF, 8'hFF, 8'h09, 8'h03, 8'h01});
    vecs[6] = mk(16'd42,    3'd1, 1'b0, {8'h71, 8'h9F, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'h25});

    // Reset state and idle scan.
    do_reset("reset");
    check_digits(ZERO_DISP, "idle");

    // Table-driven conversions.
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].dat, vecs[v].prog, vecs[v].src);
      busy_len($sformatf("vec%0d", v), 17, 0);
      check_digits(vecs[v].dig, $sformatf("vec%0d", v));
    end

    // Latency: align so digit 0 is on screen across the 17th and 18th edges
    // (display currently 42, digit 0 = "2").
    found   = 1'b0;
    prev_an = an;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      if (an == 8'hFE && prev_an == 8'h7F) found = 1'b1;
      prev_an = an;
    end
    chk("lat/align", {31'd0, found}, 32'd1);
    repeat (16) @(posedge clk);
    #1;
    data_in = 16'd7; prog_in = 3'd0; src_in = 1'b0; data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    chk("lat/edge17_an",  {24'd0, an},      32'hFE);
    chk("lat/edge17_old", {24'd0, dec_ddp}, 32'h25);
    @(posedge clk);
    @(negedge clk);
    chk("lat/edge18_an",  {24'd0, an},      32'hFE);
    chk("lat/edge18_new", {24'd0, dec_ddp}, 32'h1F);
    chk("lat/busy_done",  {31'd0, busy},    32'd0);
    check_digits(vecs[1].dig, "lat");

    // Pending, last wins: 100, 200, 300 arrive back to back during an earlier conversion.
    @(negedge clk);
    data_in = 16'd65535; prog_in = 3'd5; src_in = 1'b1; data_valid = 1'b1;
    @(posedge clk);
    #1 data_in = 16'd100; prog_in = 3'd4;
    @(posedge clk);
    #1 data_in = 16'd200; prog_in = 3'd6;
    @(posedge clk);
    #1 data_in = 16'd300; prog_in = 3'd2; src_in = 1'b0;
    @(posedge clk);
    #1 data_valid = 1'b0;
    busy_len("pend", 34, 3);
    check_digits({8'h71, 8'h25, 8'hFE, 8'hFF, 8'hFF, 8'h0D, 8'h03, 8'h03}, "pend");

    // Reset mid-conversion: nothing partial may reach the display.
    send(16'd12345, 3'd3, 1'b1);
    repeat (8) @(posedge clk);
    do_reset("midrst");
    check_digits(ZERO_DISP, "midrst");
    send(16'd42, 3'd1, 1'b0);
    busy_len("after_rst", 17, 0);
    check_digits(vecs[6].dig, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
